// File: rtl/aes_spi8_rx_if.sv
`timescale 1ns/1ps
// Block output channel of the AES SPI receiver: 128-bit payload with a valid/ready handshake.
interface aes_spi8_rx_if;
  logic [127:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;

  modport master (output blk_data, output blk_valid, input blk_ready);
  modport slave  (input blk_data, input blk_valid, output blk_ready);
endinterface

// File: rtl/aes_spi8_rx.sv
`timescale 1ns/1ps
// 8-lane parallel SPI receiver: packs 16 bytes per frame into a 128-bit block and queues it in a FIFO.
// Defining AES_SPI8_RX_TIMEOUT_EN aborts a frame after TIMEOUT_CYC idle clk cycles mid-frame.
module aes_spi8_rx #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    spi_data,
  input  logic          spi_clk,
  input  logic          spi_cs_n,
  aes_spi8_rx_if.master blk,
  output logic          rx_busy,
  output logic          frame_err,
  output logic          overflow,
  input  logic          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_COMMIT, ST_ABORT} state_e;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Input synchronizers; the third stage keeps data aligned with the registered edge pulses.
  logic [7:0] data_s1_q, data_s2_q, data_s3_q;
  logic       clk_s1_q, clk_s2_q, clk_s3_q;
  logic       cs_s1_q, cs_s2_q, cs_s3_q;
  logic       clk_rise_q, cs_rise_q, cs_fall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      data_s3_q  <= '0;
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      clk_s3_q   <= 1'b0;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_s3_q    <= 1'b1;
      clk_rise_q <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage see the previous value, forming a real pipeline.
      data_s1_q  <= spi_data;
      data_s2_q  <= data_s1_q;
      data_s3_q  <= data_s2_q;
      clk_s1_q   <= spi_clk;
      clk_s2_q   <= clk_s1_q;
      clk_s3_q   <= clk_s2_q;
      cs_s1_q    <= spi_cs_n;
      cs_s2_q    <= cs_s1_q;
      cs_s3_q    <= cs_s2_q;
      clk_rise_q <= clk_s2_q & ~clk_s3_q;
      cs_rise_q  <= cs_s2_q & ~cs_s3_q;
      cs_fall_q  <= ~cs_s2_q & cs_s3_q;
    end
  end

  state_e       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [127:0] shreg_q, shreg_d;
  logic         ferr_q, ferr_d, ovf_q, ovf_d;
  logic         commit, ferr_set, ovf_set, timeout;

  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic [127:0] mem_q [FIFO_DEPTH];
  logic         fifo_empty, fifo_full, push, pop;

`ifdef AES_SPI8_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt_q;

  assign timeout = (idle_cnt_q == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idle_cnt_q <= '0;
    end else if (state_q != ST_RECV || clk_rise_q) begin
      idle_cnt_q <= '0;
    end else if (!timeout) begin
      idle_cnt_q <= idle_cnt_q + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    commit   = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_q) begin
          state_d = ST_RECV;
          cnt_d   = '0;
        end
      end
      ST_RECV: begin
        if (clk_rise_q && cnt_q == 5'd16) begin
          state_d  = ST_ABORT;
          ferr_set = 1'b1;
        end else begin
          // A strobe coinciding with cs_n rising is captured before the frame is judged.
          if (clk_rise_q) begin
            shreg_d = {shreg_q[119:0], data_s3_q};
            cnt_d   = cnt_q + 5'd1;
          end
          if (cs_rise_q) begin
            if (cnt_d == 5'd16) begin
              state_d = ST_COMMIT;
            end else begin
              state_d  = ST_IDLE;
              ferr_set = 1'b1;
            end
          end else if (timeout && !clk_rise_q) begin
            state_d  = ST_ABORT;
            ferr_set = 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ABORT: begin
        if (cs_s3_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && blk.blk_ready;
  assign push       = commit && (!fifo_full || pop);
  assign ovf_set    = commit && !push;

  // A set event in the same cycle as err_clr keeps the flag high.
  assign ferr_d = ferr_set | (ferr_q & ~err_clr);
  assign ovf_d  = ovf_set | (ovf_q & ~err_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ferr_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
  end

  assign blk.blk_valid = !fifo_empty;
  assign blk.blk_data  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign rx_busy       = (state_q != ST_IDLE);
  assign frame_err     = ferr_q;
  assign overflow      = ovf_q;
endmodule

// File: tb/tb_aes_spi8_rx.sv
`timescale 1ns/1ps
// Scoreboard bench for aes_spi8_rx: frames are bit-banged on the SPI pins, expected blocks are queued
// from a byte-level model and compared by an independent monitor as the consumer accepts them.
module tb_aes_spi8_rx;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 1024;

  typedef logic [7:0] bytes_t[$];

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] spi_data = 8'h00;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       err_clr = 1'b0;
  logic       rx_busy, frame_err, overflow;

  aes_spi8_rx_if blk ();

  aes_spi8_rx #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .spi_data  (spi_data),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .blk       (blk),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overflow  (overflow),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  int           tests = 0;
  int           fails = 0;
  logic [127:0] exp_q[$];
  logic         exp_ferr = 1'b0;
  logic         exp_ovf = 1'b0;
  int           ready_mode = 0;  // 0: low, 1: high, 2: random per cycle

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Consumer ready driver, updated a little after each rising edge.
  initial begin
    blk.blk_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       blk.blk_ready = 1'b0;
        1:       blk.blk_ready = 1'b1;
        default: blk.blk_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted block is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (resetn && blk.blk_valid && blk.blk_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_block: got %h, none expected", blk.blk_data);
      end else begin
        check("blk_data", blk.blk_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_data = b;
    tick(4);
    spi_clk = 1'b1;
    tick(4);
    spi_clk = 1'b0;
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_n = 1'b1;
    tick(10);
  endtask

  function automatic logic [127:0] pack(input bytes_t b);
    logic [127:0] v = '0;
    foreach (b[i]) v[127 - 8*i -: 8] = b[i];
    return v;
  endfunction

  function automatic bytes_t rand_bytes(input int n);
    bytes_t b;
    repeat (n) b.push_back(8'($urandom));
    return b;
  endfunction

  // Model: a 16-byte frame yields a block if there is room, else overflow; any other length is a frame error.
  task automatic model_frame(input bytes_t b);
    if (b.size() == 16) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(pack(b));
      else exp_ovf = 1'b1;
    end else begin
      exp_ferr = 1'b1;
    end
  endtask

  task automatic frame(input bytes_t b);
    model_frame(b);
    cs_low();
    foreach (b[i]) send_byte(b[i]);
    cs_high();
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, 128'(frame_err), 128'(exp_ferr));
    check({tag, "_overflow"}, 128'(overflow), 128'(exp_ovf));
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    exp_ferr = 1'b0;
    exp_ovf = 1'b0;
    tick(1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 300) begin
      tick(1);
      n++;
    end
    tick(3);
    check({tag, "_drain_left"}, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    bytes_t b;
    int     lat;
    int     lens[6] = '{16, 16, 16, 15, 17, 8};

    // Reset state
    tick(3);
    check("rst_blk_valid", 128'(blk.blk_valid), 128'(0));
    check("rst_blk_data", blk.blk_data, 128'(0));
    check("rst_rx_busy", 128'(rx_busy), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_overflow", 128'(overflow), 128'(0));
    resetn = 1'b1;
    tick(3);

    // 1: bytes 00..0F with the consumer ready; check cs_n-rise to valid latency and a one-cycle valid.
    ready_mode = 1;
    tick(2);
    b = {};
    for (int i = 0; i < 16; i++) b.push_back(8'(i));
    model_frame(b);
    cs_low();
    foreach (b[i]) send_byte(b[i]);
    check("t1_busy", 128'(rx_busy), 128'(1));
    tick(4);
    spi_cs_n = 1'b1;
    lat = 0;
    while (!blk.blk_valid && lat < 20) begin
      tick(1);
      lat++;
    end
    check("t1_latency", 128'(lat), 128'(5));
    tick(1);
    check("t1_valid_one_cycle", 128'(blk.blk_valid), 128'(0));
    tick(5);
    check("t1_done", 128'(exp_q.size()), 128'(0));
    check_flags("t1");

    // 2: five frames with the consumer stalled -> four queued, overflow; then drain in order.
    ready_mode = 0;
    tick(3);
    for (int f = 0; f < 5; f++) frame(rand_bytes(16));
    check("t2_valid", 128'(blk.blk_valid), 128'(1));
    check_flags("t2_full");
    drain("t2");
    clear_errors();
    check_flags("t2_clr");

    // 3: short frame -> frame error, no block; err_clr clears it.
    frame(rand_bytes(15));
    check("t3_no_valid", 128'(blk.blk_valid), 128'(0));
    check_flags("t3");
    clear_errors();
    check_flags("t3_clr");

    // 4: long frame aborts; the following good frame is received.
    frame(rand_bytes(17));
    check_flags("t4_long");
    check("t4_idle", 128'(rx_busy), 128'(0));
    frame(rand_bytes(16));
    tick(4);
    check("t4_done", 128'(exp_q.size()), 128'(0));
    clear_errors();

    // 5: FIFO holds 3; consumer pops exactly in the commit cycle of the 4th frame.
    ready_mode = 0;
    tick(3);
    for (int f = 0; f < 3; f++) frame(rand_bytes(16));
    b = rand_bytes(16);
    model_frame(b);
    cs_low();
    foreach (b[i]) send_byte(b[i]);
    tick(4);
    spi_cs_n = 1'b1;
    tick(4);
    ready_mode = 1;
    tick(1);
    ready_mode = 0;
    tick(10);
    check("t5_exp_left", 128'(exp_q.size()), 128'(3));
    check_flags("t5");
    drain("t5");

    // 6: stall for 1100 clk after byte 7.
    ready_mode = 1;
    b = rand_bytes(16);
    cs_low();
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    tick(1100);
`ifdef AES_SPI8_RX_TIMEOUT_EN
    exp_ferr = 1'b1;
    check_flags("t6_timeout");
    for (int i = 8; i < 16; i++) send_byte(b[i]);
    cs_high();
    check("t6_idle", 128'(rx_busy), 128'(0));
    check("t6_no_valid", 128'(blk.blk_valid), 128'(0));
    clear_errors();
`else
    check("t6_still_busy", 128'(rx_busy), 128'(1));
    check_flags("t6_wait");
    model_frame(b);
    for (int i = 8; i < 16; i++) send_byte(b[i]);
    cs_high();
    tick(4);
    check("t6_done", 128'(exp_q.size()), 128'(0));
`endif

    // Async reset mid-frame discards the partial block and the FIFO contents.
    ready_mode = 0;
    tick(3);
    frame(rand_bytes(16));
    frame(rand_bytes(16));
    cs_low();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    resetn = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf = 1'b0;
    tick(2);
    check("rst_mid_valid", 128'(blk.blk_valid), 128'(0));
    check("rst_mid_busy", 128'(rx_busy), 128'(0));
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    resetn = 1'b1;
    tick(4);
    ready_mode = 1;
    frame(rand_bytes(16));
    tick(4);
    check("rst_mid_after", 128'(exp_q.size()), 128'(0));

    // Randomised frames with a randomly stalling consumer.
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      frame(rand_bytes(lens[$urandom_range(0, 5)]));
      check_flags("rand");
      if ($urandom_range(0, 2) == 0) clear_errors();
    end
    drain("rand");
    check_flags("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
